// File: rtl/lsu_mem_ctrl.sv
// Load/store initiator between the CPU execute stage and a byte-addressed data memory.
// Optional build macro MISALIGN_TRAP_EN turns misaligned halfword/word accesses into errors.
module lsu_mem_ctrl #(
  parameter int ADDR_W = 12,
  parameter int XLEN   = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [2:0]        req_funct3,
  input  logic [XLEN-1:0]   req_addr,
  input  logic [XLEN-1:0]   req_wdata,
  output logic              resp_valid,
  output logic [XLEN-1:0]   resp_rdata,
  output logic              resp_err,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [XLEN-1:0]   mem_wdata,
  input  logic [XLEN-1:0]   mem_rdata
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RD   = 2'd1;
  localparam logic [1:0] WR   = 2'd2;
  localparam logic [1:0] RESP = 2'd3;

  // Highest legal word start: the memory always touches four bytes.
  localparam logic [ADDR_W-1:0] ADDR_MAX = {{(ADDR_W-2){1'b1}}, 2'b00};

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  function automatic logic funct3_bad(input logic we, input logic [2:0] f3);
    logic bad;
    if (we) begin
      bad = (f3 > F3_W);
    end else begin
      bad = (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111);
    end
    return bad;
  endfunction

  function automatic logic [XLEN-1:0] load_extend(input logic [2:0] f3, input logic [XLEN-1:0] d);
    logic [XLEN-1:0] r;
    case (f3)
      F3_B:    r = {{(XLEN-8){d[7]}}, d[7:0]};
      F3_H:    r = {{(XLEN-16){d[15]}}, d[15:0]};
      F3_BU:   r = {{(XLEN-8){1'b0}}, d[7:0]};
      F3_HU:   r = {{(XLEN-16){1'b0}}, d[15:0]};
      default: r = d;
    endcase
    return r;
  endfunction

  function automatic logic [XLEN-1:0] store_merge(input logic [2:0] f3, input logic [XLEN-1:0] rd,
                                                 input logic [XLEN-1:0] wd);
    logic [XLEN-1:0] r;
    case (f3)
      F3_B:    r = {rd[XLEN-1:8], wd[7:0]};
      F3_H:    r = {rd[XLEN-1:16], wd[15:0]};
      default: r = wd;
    endcase
    return r;
  endfunction

`ifdef MISALIGN_TRAP_EN
  function automatic logic misaligned(input logic [2:0] f3, input logic [1:0] a);
    logic m;
    case (f3[1:0])
      2'b01:   m = a[0];
      2'b10:   m = |a;
      default: m = 1'b0;
    endcase
    return m;
  endfunction
`endif

  logic [1:0]        state_r, state_nx_s;
  logic              we_r, we_nx_s;
  logic [2:0]        funct3_r, funct3_nx_s;
  logic [XLEN-1:0]   wdata_r, wdata_nx_s;
  logic [ADDR_W-1:0] addr_r, addr_nx_s;
  logic              mem_read_r, mem_read_nx_s;
  logic              mem_write_r, mem_write_nx_s;
  logic [XLEN-1:0]   mem_wdata_r, mem_wdata_nx_s;
  logic              resp_valid_r, resp_valid_nx_s;
  logic              resp_err_r, resp_err_nx_s;
  logic [XLEN-1:0]   resp_rdata_r, resp_rdata_nx_s;
  logic              req_ready_r, req_ready_nx_s;

  logic [ADDR_W-1:0] req_addr_s;
  logic              req_err_s;
  logic              unused_addr_s;

  assign req_addr_s    = req_addr[ADDR_W-1:0];
  assign unused_addr_s = ^req_addr[XLEN-1:ADDR_W];

  // Request rejection: bad funct3, out-of-range start address, optional misalignment.
  always_comb begin
`ifdef MISALIGN_TRAP_EN
    req_err_s = funct3_bad(req_we, req_funct3) || (req_addr_s > ADDR_MAX) ||
                misaligned(req_funct3, req_addr_s[1:0]);
`else
    req_err_s = funct3_bad(req_we, req_funct3) || (req_addr_s > ADDR_MAX);
`endif
  end

  // Next-state and next-output computation; every strobe defaults low.
  always_comb begin
    state_nx_s      = state_r;
    we_nx_s         = we_r;
    funct3_nx_s     = funct3_r;
    wdata_nx_s      = wdata_r;
    addr_nx_s       = addr_r;
    mem_read_nx_s   = 1'b0;
    mem_write_nx_s  = 1'b0;
    mem_wdata_nx_s  = mem_wdata_r;
    resp_valid_nx_s = 1'b0;
    resp_err_nx_s   = resp_err_r;
    resp_rdata_nx_s = resp_rdata_r;
    case (state_r)
      IDLE: begin
        if (req_valid && req_ready_r) begin
          we_nx_s     = req_we;
          funct3_nx_s = req_funct3;
          wdata_nx_s  = req_wdata;
          addr_nx_s   = req_addr_s;
          if (req_err_s) begin
            state_nx_s      = RESP;
            resp_valid_nx_s = 1'b1;
            resp_err_nx_s   = 1'b1;
            resp_rdata_nx_s = {XLEN{1'b0}};
          end else if (req_we && (req_funct3 == F3_W)) begin
            state_nx_s     = WR;
            mem_write_nx_s = 1'b1;
            mem_wdata_nx_s = req_wdata;
          end else begin
            // Loads and sub-word stores both start with a read.
            state_nx_s    = RD;
            mem_read_nx_s = 1'b1;
          end
        end else begin
          state_nx_s = IDLE;
        end
      end
      RD: begin
        if (we_r) begin
          state_nx_s     = WR;
          mem_write_nx_s = 1'b1;
          mem_wdata_nx_s = store_merge(funct3_r, mem_rdata, wdata_r);
        end else begin
          state_nx_s      = RESP;
          resp_valid_nx_s = 1'b1;
          resp_err_nx_s   = 1'b0;
          resp_rdata_nx_s = load_extend(funct3_r, mem_rdata);
        end
      end
      WR: begin
        state_nx_s      = RESP;
        resp_valid_nx_s = 1'b1;
        resp_err_nx_s   = 1'b0;
        resp_rdata_nx_s = {XLEN{1'b0}};
      end
      RESP: begin
        state_nx_s = IDLE;
      end
      default: begin
        state_nx_s = IDLE;
      end
    endcase
    req_ready_nx_s = (state_nx_s == IDLE);
  end

  // State and registered outputs; reset drops every strobe at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= IDLE;
      we_r         <= 1'b0;
      funct3_r     <= 3'b000;
      wdata_r      <= {XLEN{1'b0}};
      addr_r       <= {ADDR_W{1'b0}};
      mem_read_r   <= 1'b0;
      mem_write_r  <= 1'b0;
      mem_wdata_r  <= {XLEN{1'b0}};
      resp_valid_r <= 1'b0;
      resp_err_r   <= 1'b0;
      resp_rdata_r <= {XLEN{1'b0}};
      req_ready_r  <= 1'b0;
    end else begin
      state_r      <= state_nx_s;
      we_r         <= we_nx_s;
      funct3_r     <= funct3_nx_s;
      wdata_r      <= wdata_nx_s;
      addr_r       <= addr_nx_s;
      mem_read_r   <= mem_read_nx_s;
      mem_write_r  <= mem_write_nx_s;
      mem_wdata_r  <= mem_wdata_nx_s;
      resp_valid_r <= resp_valid_nx_s;
      resp_err_r   <= resp_err_nx_s;
      resp_rdata_r <= resp_rdata_nx_s;
      req_ready_r  <= req_ready_nx_s;
    end
  end

  assign req_ready  = req_ready_r;
  assign resp_valid = resp_valid_r;
  assign resp_rdata = resp_rdata_r;
  assign resp_err   = resp_err_r;
  assign mem_read   = mem_read_r;
  assign mem_write  = mem_write_r;
  assign mem_addr   = addr_r;
  assign mem_wdata  = mem_wdata_r;

endmodule

// File: doc/lsu_mem_ctrl.md
Name: lsu_mem_ctrl

Overview:
- Load/store initiator between the CPU execute stage and the byte-addressed 4 KiB data memory.
- Decodes RV32I load/store funct3 and drives the memory's mem_read/mem_write/addr/data_in interface.
- Performs sub-word stores as read-modify-write, because the memory always writes 4 bytes.
- Returns sign- or zero-extended load data through a valid/ready request and a one-cycle response pulse.

Parameters:
- ADDR_W, 12, memory byte-address width; accesses are legal only when addr[ADDR_W-1:0] <= 2^ADDR_W-4.
- XLEN, 32, CPU data width.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  1  CPU requests an access.
- req_ready  out  1  block is able to accept a request.
- req_we  in  1  1 = store, 0 = load.
- req_funct3  in  3  RV32I funct3 (LB/LH/LW/LBU/LHU, SB/SH/SW).
- req_addr  in  XLEN  byte address; bits above ADDR_W are ignored.
- req_wdata  in  XLEN  store data, low-aligned.
- resp_valid  out  1  one-cycle pulse: access complete.
- resp_rdata  out  XLEN  extended load data; 0 for stores and errors.
- resp_err  out  1  qualified by resp_valid; access rejected.
- mem_read  out  1  memory read strobe.
- mem_write  out  1  memory write enable, sampled by memory on posedge.
- mem_addr  out  ADDR_W  byte address to the memory.
- mem_wdata  out  XLEN  write data to the memory.
- mem_rdata  in  XLEN  memory read data, valid while mem_read=1.

Behaviour:
- Reset while rst_n=0:
  - state=IDLE.
  - mem_read, mem_write, resp_valid, resp_err, req_ready all 0.
  - mem_addr, mem_wdata, resp_rdata all 0.
  - req_ready=1 from the first clock edge after rst_n rises.
- FSM states: IDLE, RD, WR, RESP. req_ready=1 only in IDLE.
- Accept: req_valid && req_ready at a posedge.
  - Latch we, funct3, addr[ADDR_W-1:0] and wdata.
  - Drive mem_addr = latched addr, held until the block returns to IDLE.
- Error check at accept. An error goes straight to RESP with resp_err=1, and mem_read/mem_write stay 0. Error causes:
  - Unsupported funct3: loads 011/110/111; stores other than 000/001/010.
  - Out-of-range: addr > 2^ADDR_W-4.
- Routing at accept:
  - Load -> RD.
  - SB/SH -> RD.
  - SW -> WR, with mem_wdata = wdata.
- RD:
  - mem_read=1 for exactly one cycle, rising at state entry. The memory updates only on a mem_read transition, so mem_read must return to 0 between accesses.
  - mem_rdata is captured at the posedge leaving RD.
  - Load -> RESP, with resp_rdata = the low 1/2/4 bytes of the captured data: sign-extended for LB/LH, zero-extended for LBU/LHU, unchanged for LW.
  - SB -> WR, with mem_wdata = {rdata[31:8], wdata[7:0]}.
  - SH -> WR, with mem_wdata = {rdata[31:16], wdata[15:0]}.
- WR: mem_write=1 for exactly one cycle. The memory commits at the posedge leaving WR; the next state is RESP.
- RESP:
  - resp_valid=1 for one cycle, then -> IDLE.
  - resp_rdata and resp_err hold their values until the next RESP.
- Latency from the accept edge to resp_valid high:
  - load: 2 cycles.
  - SW: 2 cycles.
  - SB/SH: 3 cycles.
  - error: 1 cycle.
- Throughput: one access per (latency+1) cycles. req_valid held during a busy period is ignored until IDLE.
- Misaligned accesses without the optional feature: performed at the raw byte address. The memory is byte-lane addressed, so the result is little-endian and correct.
- Reset mid-operation: all strobes drop immediately and no memory write occurs, including when reset is asserted during WR before its edge. No response is issued.

Optional Feature:
- MISALIGN_TRAP_EN defined:
  - Halfword access with addr[0]!=0 is an error.
  - Word access with addr[1:0]!=0 is an error.
  - Either is handled like any other error: resp_err=1, latency 1, no memory strobe.
- MISALIGN_TRAP_EN undefined: misaligned accesses proceed as above, and resp_err reflects only funct3/range errors.

Test Plan:
- SW addr=0x010 wdata=0xDEADBEEF, then LW 0x010 -> mem_write pulses once with mem_wdata=0xDEADBEEF; load response 0xDEADBEEF 2 cycles after accept; resp_err=0.
- With 0x010 holding 0xDEADBEEF, SB 0x010 wdata=0x000000A5 -> RD then WR; mem_wdata=0xDEADBEA5; a following LB 0x010 returns 0xFFFFFFA5 and LBU returns 0x000000A5.
- With 0x020 holding 0x00008001: LH 0x020 -> 0xFFFF8001; LHU -> 0x00008001; SH 0x020 wdata=0x1234 then LW -> 0x00001234.
- LW 0xFFD (range), then load funct3=3'b011 -> each gives resp_valid with resp_err=1 one cycle after accept; mem_read/mem_write never assert.
- LW 0x011 -> without MISALIGN_TRAP_EN, returns the bytes 0x011..0x014 little-endian with resp_err=0; with MISALIGN_TRAP_EN, resp_err=1 and no mem_read.
- Assert rst_n=0 during the WR cycle of SB 0x030 -> mem_write drops immediately, memory at 0x030 is unchanged, no resp_valid, and req_ready=1 one edge after release.
